// File: rtl/bellman_relax.sv
// Bellman-Ford relaxation engine: initialises vertmat from a source vertex, then
// sweeps every adjmat edge row-major, writing improved distance/predecessor words.
module bellman_relax #(
  parameter int NODES    = 32,
  parameter int PRED_W   = 5,
  parameter int WEIGHT_W = 16,
  parameter int VERT_W   = PRED_W + WEIGHT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                relax_start,
  input  logic [PRED_W-1:0]   src_vertex,
  input  logic [WEIGHT_W-1:0] adjmat_q,
  input  logic [VERT_W-1:0]   vertmat_q_a,
  input  logic [VERT_W-1:0]   vertmat_q_b,
  output logic [PRED_W-1:0]   adjmat_row_addr,
  output logic [PRED_W-1:0]   adjmat_col_addr,
  output logic [PRED_W-1:0]   vertmat_addr_a,
  output logic [PRED_W-1:0]   vertmat_addr_b,
  output logic [VERT_W-1:0]   vertmat_data_b,
  output logic                vertmat_we_b,
  output logic [PRED_W-1:0]   pass_count,
  output logic                relax_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_RELAX,
    S_DONE
  } state_t;

  localparam logic [PRED_W-1:0]          LAST    = PRED_W'(NODES - 1);
  localparam logic signed [WEIGHT_W-1:0] INF     = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] SAT_NEG = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [WEIGHT_W-1:0] SAT_POS = {1'b0, {(WEIGHT_W-2){1'b1}}, 1'b0};

  state_t              state_q;
  logic [PRED_W-1:0]   i_q;
  logic [PRED_W-1:0]   j_q;
  logic [PRED_W-1:0]   src_q;
  logic [PRED_W-1:0]   pass_q;
  logic                done_q;
  logic                upd_q;

  logic signed [WEIGHT_W-1:0] svw;
  logic signed [WEIGHT_W-1:0] dvw;
  logic signed [WEIGHT_W-1:0] edgeW;
  logic signed [WEIGHT_W:0]   sum;
  logic signed [WEIGHT_W:0]   dvwExt;
  logic signed [WEIGHT_W-1:0] satSum;
  logic signed [WEIGHT_W-1:0] initDist;
  logic                       relaxHit;
  logic                       lastEdge;
  logic                       unusedPredBits;

  assign svw    = vertmat_q_a[WEIGHT_W-1:0];
  assign dvw    = vertmat_q_b[WEIGHT_W-1:0];
  assign edgeW  = adjmat_q;
  assign sum    = {svw[WEIGHT_W-1], svw} + {edgeW[WEIGHT_W-1], edgeW};
  assign dvwExt = {dvw[WEIGHT_W-1], dvw};
  assign unusedPredBits = ^{vertmat_q_a[VERT_W-1:WEIGHT_W], vertmat_q_b[VERT_W-1:WEIGHT_W]};

  // The comparison uses the full-width sum; only the stored value is clamped.
  assign relaxHit = (state_q == S_RELAX) && (edgeW != '0) && (i_q != j_q) &&
                    (svw != INF) && (sum < dvwExt);
  assign lastEdge = (i_q == LAST) && (j_q == LAST);
  assign initDist = (j_q == src_q) ? '0 : INF;

  always_comb begin
    satSum = sum[WEIGHT_W-1:0];
    if (sum[WEIGHT_W] != sum[WEIGHT_W-1]) begin
      satSum = sum[WEIGHT_W] ? SAT_NEG : SAT_POS;
    end
  end

  // Write port is driven straight from the registered state so reset kills it at once.
  always_comb begin
    vertmat_we_b   = 1'b0;
    vertmat_data_b = '0;
    if (state_q == S_INIT) begin
      vertmat_we_b   = 1'b1;
      vertmat_data_b = {j_q, initDist};
    end else if (relaxHit) begin
      vertmat_we_b   = 1'b1;
      vertmat_data_b = {i_q, satSum};
    end
  end

  assign adjmat_row_addr = i_q;
  assign adjmat_col_addr = j_q;
  assign vertmat_addr_a  = i_q;
  assign vertmat_addr_b  = j_q;
  assign pass_count      = pass_q;
  assign relax_done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      src_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (relax_start) begin
            src_q   <= src_vertex;
            done_q  <= 1'b0;
            pass_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            upd_q   <= 1'b0;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          if (j_q == LAST) begin
            i_q <= '0;
            j_q <= '0;
            if (NODES == 1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_RELAX;
        end
        S_RELAX: begin
          if (lastEdge) begin
            pass_q <= pass_q + 1'b1;
            // Stop after NODES-1 passes, or early once a whole pass changed nothing.
            if ((pass_q + 1'b1 == LAST) || !(upd_q || relaxHit)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              upd_q   <= 1'b0;
              i_q     <= '0;
              j_q     <= '0;
              state_q <= S_FETCH;
            end
          end else begin
            upd_q <= upd_q | relaxHit;
            if (j_q == LAST) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bellman_relax.sv
// Self-checking bench for bellman_relax at NODES=4: bench-owned memories, an
// algorithm-level Bellman-Ford model producing the expected write stream, and directed cases.
module tb_bellman_relax;

  localparam int N   = 4;
  localparam int PW  = 2;
  localparam int WW  = 16;
  localparam int VW  = 18;
  localparam int INF = 32767;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          relax_start = 1'b0;
  logic [PW-1:0] src_vertex = '0;
  logic [WW-1:0] adjmat_q;
  logic [VW-1:0] vertmat_q_a;
  logic [VW-1:0] vertmat_q_b;
  logic [PW-1:0] adjmat_row_addr;
  logic [PW-1:0] adjmat_col_addr;
  logic [PW-1:0] vertmat_addr_a;
  logic [PW-1:0] vertmat_addr_b;
  logic [VW-1:0] vertmat_data_b;
  logic          vertmat_we_b;
  logic [PW-1:0] pass_count;
  logic          relax_done;

  bellman_relax #(.NODES(N), .PRED_W(PW), .WEIGHT_W(WW), .VERT_W(VW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .relax_start(relax_start),
    .src_vertex(src_vertex),
    .adjmat_q(adjmat_q),
    .vertmat_q_a(vertmat_q_a),
    .vertmat_q_b(vertmat_q_b),
    .adjmat_row_addr(adjmat_row_addr),
    .adjmat_col_addr(adjmat_col_addr),
    .vertmat_addr_a(vertmat_addr_a),
    .vertmat_addr_b(vertmat_addr_b),
    .vertmat_data_b(vertmat_data_b),
    .vertmat_we_b(vertmat_we_b),
    .pass_count(pass_count),
    .relax_done(relax_done)
  );

  always #5 clk = ~clk;

  logic signed [WW-1:0] adj [N][N];
  logic [VW-1:0]        vert [N];

  // Synchronous memories: one-cycle read latency, read-before-write on the same edge.
  always @(posedge clk) begin
    adjmat_q    <= adj[adjmat_row_addr][adjmat_col_addr];
    vertmat_q_a <= vert[vertmat_addr_a];
    vertmat_q_b <= vert[vertmat_addr_b];
    if (vertmat_we_b) vert[vertmat_addr_b] <= vertmat_data_b;
  end

  typedef struct {
    int          addr;
    logic [VW-1:0] data;
  } wr_t;

  wr_t expQ[$];
  wr_t w;
  int  expDist [N];
  int  expPred [N];
  int  expPasses;
  int  total = 0;
  int  bad = 0;
  bit  active = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] word(input int p, input int d);
    return {PW'(p), WW'(d)};
  endfunction

  // Textbook Bellman-Ford over plain arrays, recording every write in sweep order.
  task automatic buildModel(input int src);
    int  s;
    int  sat;
    bit  upd;
    expQ.delete();
    for (int n = 0; n < N; n++) begin
      expDist[n] = (n == src) ? 0 : INF;
      expPred[n] = n;
      expQ.push_back('{n, word(n, expDist[n])});
    end
    expPasses = 0;
    for (int p = 0; p < N - 1; p++) begin
      upd = 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (adj[i][j] != 0 && i != j && expDist[i] != INF) begin
            s = expDist[i] + int'(adj[i][j]);
            if (s < expDist[j]) begin
              sat = s;
              if (s < -32768) sat = -32768;
              if (s > 32767) sat = 32766;
              expDist[j] = sat;
              expPred[j] = i;
              expQ.push_back('{j, word(i, sat)});
              upd = 1'b1;
            end
          end
        end
      end
      expPasses = p + 1;
      if (!upd) break;
    end
  endtask

  always @(negedge clk) begin
    if (active && reset_n) begin
      checkOutput("addr_a tracks row", 32'(vertmat_addr_a), 32'(adjmat_row_addr));
      if (vertmat_we_b) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious write", 32'(vertmat_data_b), 32'hDEAD_BEEF);
        end else begin
          w = expQ.pop_front();
          checkOutput("write addr", 32'(vertmat_addr_b), 32'(w.addr));
          checkOutput("write data", 32'(vertmat_data_b), 32'(w.data));
        end
      end
    end
  end

  task automatic clearAdj();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        adj[i][j] = '0;
  endtask

  task automatic applyStimulus(input int src, input bit pokeStart, output int cycles);
    buildModel(src);
    active = 1'b1;
    @(posedge clk); #1;
    src_vertex  = PW'(src);
    relax_start = 1'b1;
    @(posedge clk); #1;
    relax_start = 1'b0;
    cycles = 1;
    checkOutput("done cleared on start", 32'(relax_done), 32'd0);
    while (!relax_done && cycles < 2000) begin
      if (pokeStart && cycles == 12) begin
        relax_start = 1'b1;
        src_vertex  = PW'(3);
      end else begin
        relax_start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    relax_start = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(1 + N + expPasses * 2 * N * N));
    checkOutput("pass_count", 32'(pass_count), 32'(expPasses));
    checkOutput("writes outstanding", 32'(expQ.size()), 32'd0);
    for (int n = 0; n < N; n++)
      checkOutput($sformatf("vert[%0d] vs model", n), 32'(vert[n]),
                  32'(word(expPred[n], expDist[n])));
    active = 1'b0;
  endtask

  int cyc;
  bit found;

  initial begin
    clearAdj();
    #3;
    checkOutput("reset we_b", 32'(vertmat_we_b), 32'd0);
    checkOutput("reset data_b", 32'(vertmat_data_b), 32'd0);
    checkOutput("reset pass_count", 32'(pass_count), 32'd0);
    checkOutput("reset relax_done", 32'(relax_done), 32'd0);
    checkOutput("reset addr_b", 32'(vertmat_addr_b), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("[TB] init only, src=2");
    applyStimulus(2, 1'b0, cyc);
    checkOutput("init word 0", 32'(vert[0]), 32'(word(0, INF)));
    checkOutput("init word 1", 32'(vert[1]), 32'(word(1, INF)));
    checkOutput("init word 2", 32'(vert[2]), 32'(word(2, 0)));
    checkOutput("init word 3", 32'(vert[3]), 32'(word(3, INF)));
    checkOutput("init pass_count", 32'(pass_count), 32'd1);
    checkOutput("init latency", 32'(cyc), 32'd37);
    checkOutput("init done", 32'(relax_done), 32'd1);

    $display("[TB] chain, src=0, ignored restart mid-sweep");
    clearAdj();
    adj[0][1] = 16'sd5;
    adj[1][2] = -16'sd3;
    adj[0][2] = 16'sd4;
    applyStimulus(0, 1'b1, cyc);
    checkOutput("chain v1", 32'(vert[1]), 32'(word(0, 5)));
    checkOutput("chain v2", 32'(vert[2]), 32'(word(1, 2)));
    checkOutput("chain v3", 32'(vert[3]), 32'(word(3, INF)));
    checkOutput("chain pass_count", 32'(pass_count), 32'd2);
    checkOutput("chain latency", 32'(cyc), 32'd69);

    $display("[TB] negative cycle, src=0");
    clearAdj();
    adj[1][2] = -16'sd2;
    adj[2][1] = 16'sd1;
    adj[0][1] = 16'sd1;
    applyStimulus(0, 1'b0, cyc);
    checkOutput("negcyc v1", 32'(vert[1]), 32'(word(2, -2)));
    checkOutput("negcyc v2", 32'(vert[2]), 32'(word(1, -3)));
    checkOutput("negcyc pass_count", 32'(pass_count), 32'd3);
    checkOutput("negcyc latency", 32'(cyc), 32'd101);

    $display("[TB] saturation, src=0");
    clearAdj();
    adj[0][1] = -16'sd32768;
    adj[1][2] = -16'sd32768;
    applyStimulus(0, 1'b0, cyc);
    checkOutput("sat v1", 32'(vert[1]), 32'(word(0, -32768)));
    checkOutput("sat v2", 32'(vert[2]), 32'(word(1, -32768)));

    $display("[TB] unreachable source edge");
    clearAdj();
    adj[3][1] = -16'sd5;
    applyStimulus(0, 1'b0, cyc);
    checkOutput("unreach v1", 32'(vert[1]), 32'(word(1, INF)));
    checkOutput("unreach pass_count", 32'(pass_count), 32'd1);

    $display("[TB] reset mid-sweep");
    clearAdj();
    adj[0][1] = 16'sd5;
    adj[1][2] = -16'sd3;
    adj[0][2] = 16'sd4;
    @(posedge clk); #1;
    src_vertex  = '0;
    relax_start = 1'b1;
    @(posedge clk); #1;
    relax_start = 1'b0;
    repeat (6) @(posedge clk);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (vertmat_we_b) found = 1'b1;
    end
    checkOutput("sweep write seen", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async we_b drop", 32'(vertmat_we_b), 32'd0);
    checkOutput("reset relax_done", 32'(relax_done), 32'd0);
    checkOutput("reset pass_count", 32'(pass_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 1'b0, cyc);
    checkOutput("rerun v2", 32'(vert[2]), 32'(word(1, 2)));
    checkOutput("rerun latency", 32'(cyc), 32'd69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
